// File: rtl/full_adder_32b_if.sv
// Operand/result bundle for the registered 32-bit adder.
// master = operand producer / result consumer, slave = the adder itself.
interface full_adder_32b_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, ovf, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/full_adder_32b.sv
// Registered 32-bit adder built from 4-bit carry-lookahead groups whose
// group carries ripple from one group to the next. One clock of latency,
// result registers hold while no qualified input arrives.
module full_adder_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  full_adder_32b_if.slave  bus
);

  localparam int NGRP = WIDTH / 4;

  // Per-bit generate/propagate terms and the carry chain (w_carry[i] is the
  // carry into bit i, w_carry[WIDTH] is the carry out of the top bit).
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_zero;

  assign w_g        = bus.a & bus.b;
  assign w_p        = bus.a ^ bus.b;
  assign w_carry[0] = bus.cin;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_cla
      localparam int B = 4 * gi;

      // Internal carries of the group are computed directly from the group
      // carry-in so only the group carry-out sits on the ripple path.
      assign w_carry[B+1] = w_g[B]
                          | (w_p[B] & w_carry[B]);
      assign w_carry[B+2] = w_g[B+1]
                          | (w_p[B+1] & w_g[B])
                          | (w_p[B+1] & w_p[B] & w_carry[B]);
      assign w_carry[B+3] = w_g[B+2]
                          | (w_p[B+2] & w_g[B+1])
                          | (w_p[B+2] & w_p[B+1] & w_g[B])
                          | (w_p[B+2] & w_p[B+1] & w_p[B] & w_carry[B]);
      assign w_carry[B+4] = w_g[B+3]
                          | (w_p[B+3] & w_g[B+2])
                          | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                          | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                          | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_carry[B]);
    end
  endgenerate

  // Each cell's sum bit: a ^ b ^ carry-in.
  assign w_sum  = w_p ^ w_carry[WIDTH-1:0];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];
  assign w_zero = (w_sum == '0);

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  // Result registers: reset wins, qualified inputs load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder_32b.sv
// Self-checking bench for full_adder_32b: directed corner operands, hold
// and reset behaviour, then randomized streams against an arithmetic model.
module tb_full_adder_32b;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  full_adder_32b_if #(.WIDTH(32)) bus_if ();

  full_adder_32b #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the outputs must show after the next edge.
  logic [31:0] exp_sum;
  logic        exp_cout;
  logic        exp_ovf;
  logic        exp_zero;
  logic        exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, check one edge later.
  task automatic cycle(input logic rn, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic quiet);
    logic [32:0] full;
    rst_n           = rn;
    bus_if.in_valid = v;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.cin      = c;
    if (!rn) begin
      exp_sum   = '0;
      exp_cout  = 1'b0;
      exp_ovf   = 1'b0;
      exp_zero  = 1'b0;
      exp_valid = 1'b0;
    end else if (v) begin
      full      = {1'b0, a} + {1'b0, b} + {32'd0, c};
      exp_sum   = full[31:0];
      exp_cout  = full[32];
      exp_ovf   = (a[31] == b[31]) && (full[31] != a[31]);
      exp_zero  = (full[31:0] == 32'd0);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("sum",       bus_if.sum,              exp_sum);
    chk("cout",      {31'd0, bus_if.cout},      {31'd0, exp_cout});
    chk("ovf",       {31'd0, bus_if.ovf},       {31'd0, exp_ovf});
    chk("zero",      {31'd0, bus_if.zero},      {31'd0, exp_zero});
    chk("out_valid", {31'd0, bus_if.out_valid}, {31'd0, exp_valid});
    if (!quiet)
      $display("txn rst_n=%0b v=%0b a=%h b=%h cin=%0b -> sum=%h cout=%0b ovf=%0b zero=%0b ov=%0b",
               rn, v, a, b, c, bus_if.sum, bus_if.cout, bus_if.ovf, bus_if.zero, bus_if.out_valid);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] special [6];
    special[0] = 32'h0000_0000;
    special[1] = 32'hFFFF_FFFF;
    special[2] = 32'h8000_0000;
    special[3] = 32'h7FFF_FFFF;
    special[4] = 32'h0000_0001;
    special[5] = 32'hFFFF_FFFE;
    if ($urandom_range(0, 3) == 0)
      return special[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  logic [31:0] dir_a [8];
  logic [31:0] dir_b [8];
  logic        dir_c [8];

  initial begin
    dir_a[0] = 32'h0000_0001; dir_b[0] = 32'h0000_0002; dir_c[0] = 1'b0;
    dir_a[1] = 32'hFFFF_FFFF; dir_b[1] = 32'h0000_0001; dir_c[1] = 1'b0;
    dir_a[2] = 32'h8000_0000; dir_b[2] = 32'h8000_0000; dir_c[2] = 1'b0;
    dir_a[3] = 32'h0000_000F; dir_b[3] = 32'h0000_0001; dir_c[3] = 1'b1;
    dir_a[4] = 32'h0000_0005; dir_b[4] = 32'hFFFF_FFFF; dir_c[4] = 1'b0;
    dir_a[5] = 32'hFFFF_FFF0; dir_b[5] = 32'hFFFF_FFF0; dir_c[5] = 1'b0;
    dir_a[6] = 32'h7FFF_FFFF; dir_b[6] = 32'h0000_0001; dir_c[6] = 1'b0;
    dir_a[7] = 32'hFFFF_FFFF; dir_b[7] = 32'hFFFF_FFFF; dir_c[7] = 1'b1;

    rst_n           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.a        = '0;
    bus_if.b        = '0;
    bus_if.cin      = 1'b0;

    // Reset with a qualified operand present: operand must be discarded.
    cycle(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Directed corner cases, back to back.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, dir_a[i], dir_b[i], dir_c[i], 1'b0);

    // Load a non-zero result, then idle: outputs hold, out_valid drops.
    cycle(1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, $urandom, $urandom, 1'($urandom), 1'b0);

    // Reset mid-stream with in_valid high clears everything.
    cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    // After release: idle cycle keeps out_valid low, then first result.
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back random stream with toggling carry-in.
    for (int i = 0; i < 2000; i++)
      cycle(1'b1, 1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'b0);

    // Random stream with gaps and occasional resets.
    for (int i = 0; i < 1000; i++)
      cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
            pick_operand(), pick_operand(), 1'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
